// File: rtl/pdm_pcm_fifo_if.sv
// pdm_pcm_fifo_if: bundles the capture, readout and status signals of the PCM sample FIFO.
//   master : driver side (decimator strobe + CPU register interface)
//   slave  : the FIFO itself
// Signals:
//   en, flush, pcm_in, pcm_valid  capture control and sample input
//   rd_en, rd_data                pop strobe and show-ahead head entry
//   empty, full, level            fill status
//   threshold, irq                level-threshold interrupt
//   overflow, ovf_clear           sticky drop flag and its clear pulse
interface pdm_pcm_fifo_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
);
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] pcm_in;
  logic             pcm_valid;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [AW:0]      level;
  logic [AW:0]      threshold;
  logic             irq;
  logic             overflow;
  logic             ovf_clear;

  modport master (
    output en, flush, pcm_in, pcm_valid, rd_en, threshold, ovf_clear,
    input  rd_data, empty, full, level, irq, overflow
  );

  modport slave (
    input  en, flush, pcm_in, pcm_valid, rd_en, threshold, ovf_clear,
    output rd_data, empty, full, level, irq, overflow
  );
endinterface

// File: rtl/pdm_pcm_fifo.sv
// pdm_pcm_fifo: sample buffer behind the CIC3 PDM decimator. Captures each PCM word strobed
// by pcm_valid, holds it for the CPU, and reports fill level, a sticky overflow flag and a
// level-threshold interrupt so samples can be read in bursts.
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active low
//   bus    pdm_pcm_fifo_if slave modport (capture, readout and status signals)
module pdm_pcm_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,  // power of 2, >= 2
  parameter int unsigned AW    = 3   // log2(DEPTH)
) (
  input logic            clk,
  input logic            rst_n,
  pdm_pcm_fifo_if.slave  bus
);

  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;

  logic empty, full, push, pop, do_write, drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == FullLevel);
  assign push  = bus.en & bus.pcm_valid;
  assign pop   = bus.rd_en & ~empty;
  // When full, a coincident pop frees the slot being written, so the push still lands.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    // Set wins over clear; a sample discarded by flush is not a drop.
    overflow_d = (overflow_q & ~bus.ovf_clear) | (drop & ~bus.flush);

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_write, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; stale entries are never visible because rd_data masks on empty.
  always_ff @(posedge clk) begin
    if (do_write && !bus.flush) begin
      mem[wr_ptr_q] <= bus.pcm_in;
    end
  end

  assign bus.rd_data  = empty ? '0 : mem[rd_ptr_q];
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  // threshold above DEPTH can never be reached, so irq stays low without a special case.
  assign bus.irq      = (bus.threshold != '0) && (level_q >= bus.threshold);

endmodule
